// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the peripheral and the master.
// Holds the mode constants, the CPOL/CPHA decode helpers and the default
// fill byte returned when the transmit holding register is empty.
package spi_pkg;

  localparam int SPI_MODE_0 = 0;
  localparam int SPI_MODE_1 = 1;
  localparam int SPI_MODE_2 = 2;
  localparam int SPI_MODE_3 = 3;

  localparam logic [7:0] FILL_BYTE_DEF = 8'hFF;

  // Idle level of SCK.
  function automatic logic cpol(input int mode);
    return (mode == SPI_MODE_2) || (mode == SPI_MODE_3);
  endfunction

  // 0: sample on the leading edge, 1: sample on the trailing edge.
  function automatic logic cpha(input int mode);
    return (mode == SPI_MODE_1) || (mode == SPI_MODE_3);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous pin.
// Ports:
//   i_Clk   - system clock
//   i_Rst_L - asynchronous active-low reset; both flops load RST_VAL
//   d_i     - asynchronous input
//   q_o     - synchronized output
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/spi_peripheral.sv
// SPI peripheral (slave) transceiver clocked entirely by i_Clk.
// SCK, CS_n and MOSI are synchronized; SCK and CS_n get an extra flop for
// edge detection. Received bytes come out as one-cycle o_RX_DV pulses; bytes
// to return on MISO are taken from a one-deep holding register (FILL_BYTE
// when it is empty at a byte boundary).
// Ports:
//   i_Clk, i_Rst_L          - system clock, async active-low reset
//   i_TX_Byte, i_TX_DV      - holding register write
//   o_TX_Ready              - holding register empty
//   o_RX_DV, o_RX_Byte      - received byte strobe and data
//   o_CS_Active             - synchronized chip select, active-high
//   i_SPI_Clk/CS_n/MOSI     - SPI pins in (asynchronous)
//   o_SPI_MISO, o_SPI_MISO_En - SPI data out and pad enable
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int         SPI_MODE  = 0,
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_CS_Active,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);

  localparam logic CPOL = cpol(SPI_MODE);
  localparam logic CPHA = cpha(SPI_MODE);

  logic       sck_s, cs_n_s, mosi_s;
  logic       sck_q, cs_n_q;
  logic [6:0] rx_shift_q;
  logic [2:0] rx_cnt_q, tx_cnt_q;
  logic [7:0] tx_shift_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [7:0] rx_byte_q;
  logic       rx_dv_q;
  logic       miso_q;

  spi_sync #(.RST_VAL(CPOL)) u_sync_sck  (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .d_i(i_SPI_Clk),  .q_o(sck_s));
  spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .d_i(i_SPI_CS_n), .q_o(cs_n_s));
  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .d_i(i_SPI_MOSI), .q_o(mosi_s));

  logic lead, trail, sample_edge, drive_edge;
  logic cs_fall, cs_rise, active;
  logic reload;
  logic [7:0] next_byte_d;

  assign lead        = (sck_q == CPOL) && (sck_s != CPOL);
  assign trail       = (sck_q != CPOL) && (sck_s == CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign drive_edge  = CPHA ? lead  : trail;

  assign cs_fall = cs_n_q  & ~cs_n_s;
  assign cs_rise = ~cs_n_q & cs_n_s;
  // SCK edges only count while CS is low on both sides of the edge flop.
  assign active  = ~cs_n_q & ~cs_n_s;

  // Holding register is consumed at CS fall and when bit 0 goes out.
  assign reload      = cs_fall | (active & drive_edge & (tx_cnt_q == 3'd7));
  assign next_byte_d = hold_full_q ? hold_q : FILL_BYTE;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sck_q       <= CPOL;
      cs_n_q      <= 1'b1;
      rx_shift_q  <= '0;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_byte_q   <= '0;
      rx_dv_q     <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sck_q   <= sck_s;
      cs_n_q  <= cs_n_s;
      rx_dv_q <= 1'b0;

      // A write always lands in holding; a coincident reload already
      // captured the old contents through next_byte_d.
      if (i_TX_DV) begin
        hold_q      <= i_TX_Byte;
        hold_full_q <= 1'b1;
      end else if (reload) begin
        hold_full_q <= 1'b0;
      end

      if (cs_rise) begin
        rx_cnt_q <= '0;
        tx_cnt_q <= '0;
      end else if (cs_fall) begin
        rx_cnt_q <= '0;
        if (!CPHA) begin
          // CPHA=0: first bit must be on the wire before the first SCK edge.
          miso_q     <= next_byte_d[7];
          tx_shift_q <= {next_byte_d[6:0], 1'b0};
          tx_cnt_q   <= 3'd1;
        end else begin
          tx_shift_q <= next_byte_d;
          tx_cnt_q   <= 3'd0;
        end
      end else if (active) begin
        if (sample_edge) begin
          rx_shift_q <= {rx_shift_q[5:0], mosi_s};
          rx_cnt_q   <= rx_cnt_q + 3'd1;
          if (rx_cnt_q == 3'd7) begin
            rx_byte_q <= {rx_shift_q, mosi_s};
            rx_dv_q   <= 1'b1;
          end
        end
        if (drive_edge) begin
          miso_q   <= tx_shift_q[7];
          tx_cnt_q <= tx_cnt_q + 3'd1;
          if (tx_cnt_q == 3'd7) tx_shift_q <= next_byte_d;
          else                  tx_shift_q <= {tx_shift_q[6:0], 1'b0};
        end
      end
    end
  end

  assign o_TX_Ready    = ~hold_full_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_CS_Active   = ~cs_n_q;
  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_En = ~cs_n_q;

endmodule
